traffic_light_controller: RTL and testbench

//  Two-way intersection phase sequencer (NS/EW) built on the team's red/yellow/green delay arithmetic.
//  - Drives one-hot R/Y/G lamps per direction from a six-phase cycle, each phase held for a fixed tick count.
//  - Provides an optional pedestrian all-red walk phase with a request/ack handshake.
//  - Sits between the tick prescaler (en) and the lamp drivers.

---
 rtl/tlc_pkg.sv | 33 +++
 rtl/tlc_phase_timer.sv | 27 ++
 rtl/traffic_light_controller.sv | 112 +++++++++++
 tb/tb_traffic_light_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// tlc_pkg: phase encodings, lamp codes and red/yellow/green delay arithmetic
// shared by the traffic light controller and its testbench.
package tlc_pkg;

    typedef enum logic [2:0] {
        ALL_RED_EW = 3'd0,
        NS_GREEN   = 3'd1,
        NS_YELLOW  = 3'd2,
        ALL_RED_NS = 3'd3,
        EW_GREEN   = 3'd4,
        EW_YELLOW  = 3'd5,
        PED_WALK   = 3'd6
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Red is half the timer range; yellow and green split it by the ratio.
    function automatic int phase_dur(input phase_t p, input int cnt_w, input int ratio, input int all_red);
        int red;
        int yel;
        red = (1 << cnt_w) / 2;
        yel = red / (ratio + 1);
        case (p)
            NS_GREEN, EW_GREEN:   phase_dur = yel * ratio;
            NS_YELLOW, EW_YELLOW: phase_dur = yel;
            PED_WALK:             phase_dur = red;
            default:              phase_dur = all_red;
        endcase
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: loadable down-counter holding ticks remaining in the
// current phase; stops at zero and flags it.
module tlc_phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge CLK) begin
        if (!Reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (en && !zero)
            count <= count - CNT_W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: six-phase NS/EW sequencer with registered lamps.
// Define TLC_PED_EN to add the all-red pedestrian walk phase and its request/ack handshake.
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int CNT_W              = 4,
    parameter int GREEN_YELLOW_RATIO = 2,
    parameter int ALL_RED_D          = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             ped_req,
    output logic             ped_ack,
    output logic             ped_walk,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] timer
);

    localparam int RED_D = (1 << CNT_W) / 2;
    localparam int YEL_D = RED_D / (GREEN_YELLOW_RATIO + 1);

    if (YEL_D == 0) begin : g_bad_yel
        $error("traffic_light_controller: yellow duration is zero");
    end
    if (ALL_RED_D < 1 || ALL_RED_D >= (1 << CNT_W)) begin : g_bad_all_red
        $error("traffic_light_controller: ALL_RED_D out of range");
    end

    phase_t           state;
    phase_t           seq;
    phase_t           nxt;
    logic             pending;
    logic             zero;
    logic             advance;
    logic             illegal;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [2:0]       ns_nxt;
    logic [2:0]       ew_nxt;

    always_comb begin
        seq = ALL_RED_EW;
        illegal = 1'b0;
        case (state)
            ALL_RED_EW: seq = pending ? PED_WALK : NS_GREEN;
            NS_GREEN:   seq = NS_YELLOW;
            NS_YELLOW:  seq = ALL_RED_NS;
            ALL_RED_NS: seq = EW_GREEN;
            EW_GREEN:   seq = EW_YELLOW;
            EW_YELLOW:  seq = ALL_RED_EW;
`ifdef TLC_PED_EN
            PED_WALK:   seq = NS_GREEN;
`endif
            default:    illegal = 1'b1;
        endcase
        advance = en && zero;
        // Illegal encodings recover immediately, independent of the tick.
        nxt = illegal ? ALL_RED_EW : advance ? seq : state;
        load = illegal || advance;
        load_val = CNT_W'(phase_dur(nxt, CNT_W, GREEN_YELLOW_RATIO, ALL_RED_D) - 1);
        ns_nxt = nxt == NS_GREEN ? LAMP_G : nxt == NS_YELLOW ? LAMP_Y : LAMP_R;
        ew_nxt = nxt == EW_GREEN ? LAMP_G : nxt == EW_YELLOW ? LAMP_Y : LAMP_R;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= ALL_RED_EW;
            ns_light <= LAMP_R;
            ew_light <= LAMP_R;
        end else begin
            state <= nxt;
            ns_light <= ns_nxt;
            ew_light <= ew_nxt;
        end
    end

`ifdef TLC_PED_EN
    // Clearing on walk exit beats a request seen on the same edge.
    always_ff @(posedge CLK) begin
        if (!Reset)
            pending <= 1'b0;
        else if (advance && state == PED_WALK)
            pending <= 1'b0;
        else if (ped_req)
            pending <= 1'b1;
    end
    assign ped_walk = (state == PED_WALK);
`else
    assign pending  = ped_req & 1'b0;
    assign ped_walk = 1'b0;
`endif

    assign ped_ack = pending;
    assign phase   = state;

    tlc_phase_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(CNT_W'(ALL_RED_D - 1))
    ) u_timer (
        .CLK     (CLK),
        .Reset   (Reset),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .count   (timer),
        .zero    (zero)
    );

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of phase order, timing, lamps,
// reset priority, illegal-state recovery and (with TLC_PED_EN) the walk handshake.
module tb_traffic_light_controller;
    import tlc_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       en = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       ped_walk;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic [3:0] timer;

    int checks = 0;
    int failures = 0;

    // One 14-tick cycle after leaving ALL_RED_EW: G=4, Y=2, all-red=1.
    int ph_tbl[14] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 0};
    int tm_tbl[14] = '{3, 2, 1, 0, 1, 0, 0, 3, 2, 1, 0, 1, 0, 0};

    traffic_light_controller #(
        .CNT_W(4),
        .GREEN_YELLOW_RATIO(2),
        .ALL_RED_D(1)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .en(en),
        .ped_req(ped_req),
        .ped_ack(ped_ack),
        .ped_walk(ped_walk),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .phase(phase),
        .timer(timer)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int ns_exp(input int p);
        return p == 1 ? 1 : p == 2 ? 2 : 4;
    endfunction

    function automatic int ew_exp(input int p);
        return p == 4 ? 1 : p == 5 ? 2 : 4;
    endfunction

    task automatic check_state(input string tag, input int p, input int t);
        check({tag, "_phase"}, int'(phase), p);
        check({tag, "_timer"}, int'(timer), t);
        check({tag, "_ns"}, int'(ns_light), ns_exp(p));
        check({tag, "_ew"}, int'(ew_light), ew_exp(p));
        check({tag, "_conflict"}, int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        en = 1'b0;
        ped_req = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    initial begin
        #1;
        // Reset state
        do_reset();
        Reset = 1'b0;
        tick();
        check_state("rst", 0, 0);
        check("rst_ack", int'(ped_ack), 0);
        check("rst_walk", int'(ped_walk), 0);
        Reset = 1'b1;

        // 1: free-running ticks, two full cycles
        en = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tick();
            check_state($sformatf("run%0d", i), ph_tbl[i % 14], tm_tbl[i % 14]);
        end

        // 2: tick every third clock, state frozen in between
        do_reset();
        for (int j = 0; j < 42; j++) begin
            en = (j % 3 == 0);
            tick();
            check(($sformatf("slow%0d_phase", j)), int'(phase), ph_tbl[(j / 3) % 14]);
            check(($sformatf("slow%0d_timer", j)), int'(timer), tm_tbl[(j / 3) % 14]);
        end

`ifdef TLC_PED_EN
        // 3: single request during NS_GREEN
        do_reset();
        en = 1'b1;
        tick();
        ped_req = 1'b1;
        tick();
        check("ped_ack_set", int'(ped_ack), 1);
        ped_req = 1'b0;
        for (int i = 2; i < 14; i++) begin
            tick();
            check($sformatf("ped_pre%0d", i), int'(phase), ph_tbl[i]);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check_state($sformatf("walk%0d", i), 6, 7 - i);
            check($sformatf("walk%0d_lamp", i), int'(ped_walk), 1);
            check($sformatf("walk%0d_ack", i), int'(ped_ack), 1);
        end
        tick();
        check_state("walk_exit", 1, 3);
        check("walk_exit_ack", int'(ped_ack), 0);
        check("walk_exit_lamp", int'(ped_walk), 0);

        // 4: request held through walk exit re-latches once
        ped_req = 1'b1;
        tick();
        check("hold_ack", int'(ped_ack), 1);
        for (int i = 2; i < 14; i++) tick();
        check("hold_pre_walk", int'(phase), 0);
        for (int i = 0; i < 8; i++) tick();
        check("hold_last_walk", int'(phase), 6);
        tick();
        check("hold_exit_phase", int'(phase), 1);
        check("hold_exit_ack", int'(ped_ack), 0);
        tick();
        check("hold_relatch_ack", int'(ped_ack), 1);
        ped_req = 1'b0;
        begin
            int walks = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                walks += int'(ped_walk);
            end
            check("hold_one_more_walk", walks, 8);
        end
        check("hold_end_ack", int'(ped_ack), 0);
`endif

        // 5: reset mid EW_GREEN with timer=2 overrides en and ped_req
        do_reset();
        en = 1'b1;
`ifdef TLC_PED_EN
        ped_req = 1'b1;
`endif
        tick();
        ped_req = 1'b0;
        for (int i = 1; i < 9; i++) tick();
        check_state("pre_rst", 4, 2);
`ifdef TLC_PED_EN
        check("pre_rst_ack", int'(ped_ack), 1);
`endif
        Reset = 1'b0;
        ped_req = 1'b1;
        tick();
        check_state("mid_rst", 0, 0);
        check("mid_rst_ack", int'(ped_ack), 0);
        check("mid_rst_walk", int'(ped_walk), 0);

        // 6: illegal encodings recover even with en low
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check_state("pre_ill7", 4, 2);
        en = 1'b0;
        force dut.state = phase_t'(3'd7);
        #1;
        release dut.state;
        tick();
        check_state("ill7", 0, 0);
        en = 1'b1;
        tick();
        check_state("ill7_next", 1, 3);
`ifndef TLC_PED_EN
        en = 1'b0;
        force dut.state = phase_t'(3'd6);
        #1;
        release dut.state;
        tick();
        check_state("ill6", 0, 0);
        check("ill6_walk", int'(ped_walk), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
